wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Round-robin arbiter that shares one Wishbone slave-side bus between NUM_MASTERS requesting masters in the wb_conbus interconnect. It watches each master's cycle request (cyc) and grants exactly one master at a time. The grant is held for the full duration of that master's bus cycle, including burst/locked sequences while cyc stays high. It also runs a watchdog that flags an error when the granted transfer receives no slave termination within TIMEOUT cycles. The interconnect muxes address, data and strobe using gnt_idx, and ORs to_err into the owner's err input.

## Interface

Parameters:
- NUM_MASTERS, 4: number of requesters; legal range 2..8.
- TIMEOUT, 16: cycles without slave termination before to_err fires; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- m_cyc  input  NUM_MASTERS  per-master cycle request; bit i = master i.
- s_ack  input  1  slave acknowledge.
- s_err  input  1  slave error termination.
- s_rty  input  1  slave retry termination.
- gnt  output  NUM_MASTERS  one-hot grant; all zero when idle.
- gnt_idx  output  clog2(NUM_MASTERS)  index of the current owner; holds the last owner when idle.
- gnt_valid  output  1  high while any master is granted; equals |gnt.
- to_err  output  1  one-cycle watchdog error pulse for the current owner.

## Operation

- Reset values:
  - State = IDLE; gnt = 0; gnt_valid = 0; to_err = 0; watchdog counter = 0.
  - gnt_idx = NUM_MASTERS-1, so master 0 has top priority at the first arbitration.
- States:
  - IDLE: no owner.
    - If m_cyc != 0, select the winner by round-robin.
    - Search order is gnt_idx+1, gnt_idx+2, … modulo NUM_MASTERS, wrapping past NUM_MASTERS-1 to 0.
    - Next state = BUSY. Register gnt = one-hot(winner), gnt_idx = winner, gnt_valid = 1.
  - BUSY: owner = gnt_idx.
    - While m_cyc[gnt_idx] = 1, hold the grant. Requests from other masters are ignored (no preemption).
    - When m_cyc[gnt_idx] = 0, go to IDLE: gnt = 0 and gnt_valid = 0 at the next edge. gnt_idx keeps its value as the round-robin pointer.
- Watchdog (BUSY only):
  - The counter clears to 0 on entry to BUSY and in any cycle where s_ack | s_err | s_rty.
  - Otherwise it increments each cycle.
  - When counter = TIMEOUT-1 with no termination and m_cyc[gnt_idx] still high, the next edge sets to_err = 1 for exactly one cycle and clears the counter. The grant is kept; the owner is expected to drop cyc.
  - to_err is 0 in IDLE and in every other cycle.
- Boundary conditions:
  - Owner drops cyc in the same cycle the counter reaches TIMEOUT-1: the release wins and no to_err is generated.
  - A termination arrives in the same cycle the counter reaches TIMEOUT-1: the counter clears and no to_err is generated.
  - Only the owner requests continuously: it is re-granted after the mandatory IDLE cycle.
  - Bits of m_cyc that change while BUSY have no effect until the next IDLE.
  - Terminations (s_ack, s_err, s_rty) in IDLE are ignored.
  - Reset asserted mid-cycle clears all state and outputs immediately (asynchronously), regardless of clk.

## Timing

- Grant latency:
  - If m_cyc rises in IDLE during cycle n, gnt is valid in cycle n+1.
  - gnt is combinationally independent of the inputs; all outputs are registered.
- Release:
  - If the owner's cyc falls in cycle n, gnt = 0 in cycle n+1 (IDLE).
  - The next owner's gnt is valid in cycle n+2. There is exactly one dead cycle between owners.
- Watchdog:
  - With the grant valid from cycle g and no terminations, to_err is high in cycle g+TIMEOUT only.
  - If cyc stays high with no terminations, to_err repeats every TIMEOUT cycles.
- Throughput: a single master holding cyc gets back-to-back transfers with no gaps inside its cycle.

## Test plan

All scenarios use NUM_MASTERS=4, TIMEOUT=8.

1. Release rst with m_cyc=4'b0000 → gnt=0, gnt_valid=0, gnt_idx=3, to_err=0. Assert rst asynchronously mid-cycle while BUSY → all outputs return to these values before the next edge.
2. From IDLE, set m_cyc=4'b1111 and hold it; each owner drops its bit for one cycle after 3 acks, then re-requests → grant sequence 0,1,2,3,0. Each gnt is asserted 1 cycle after the request/IDLE and there is one idle cycle between owners.
3. Master 2 is granted and holds cyc for 20 cycles, acked every cycle, while m_cyc[0] is also high → gnt stays 4'b0100 for all 20 cycles and to_err stays 0. Master 0 is granted 2 cycles after master 2 drops cyc.
4. Master 1 is granted with no ack for 20 cycles → to_err pulses in cycles g+8 and g+16, and gnt stays 4'b0010 throughout.
5. Master 1 is granted with no termination; at counter=7, s_rty=1 in that same cycle → no to_err, and the counter restarts. Separately, master 1 drops cyc at counter=7 → no to_err, gnt=0 next cycle.
6. Single requester m_cyc=4'b1000 toggles cyc low/high every 4 cycles → gnt_idx stays 3 and each re-grant occurs 1 cycle after the dead IDLE cycle.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Request/grant bundle between the wb_conbus masters and the round-robin arbiter.
// The arbiter sits on the slave modport; the interconnect or bench drives the master modport.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4
) ();
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] m_cyc;
    logic                   s_ack;
    logic                   s_err;
    logic                   s_rty;
    logic [NUM_MASTERS-1:0] gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_valid;
    logic                   to_err;

    modport slave (
        input  m_cyc, s_ack, s_err, s_rty,
        output gnt, gnt_idx, gnt_valid, to_err
    );

    modport master (
        output m_cyc, s_ack, s_err, s_rty,
        input  gnt, gnt_idx, gnt_valid, to_err
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone bus arbiter with a termination watchdog.
// The grant is held for the owner's whole cyc; one dead IDLE cycle separates owners.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic            clk,
    input  logic            rst,
    wb_rr_arbiter_if.slave  bus
);
    localparam int              IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_RST = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state_q, state_next;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_next;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_next;
    logic                   gnt_valid_q, gnt_valid_next;
    logic                   to_err_q, to_err_next;
    logic [7:0]             cnt_q, cnt_next;
    logic [IDX_W-1:0]       winner;
    logic                   term;

    assign term = bus.s_ack | bus.s_err | bus.s_rty;

    // First requester after the previous owner, wrapping; gives master 0 priority out of reset.
    always_comb begin
        logic             found;
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        winner = gnt_idx_q;
        found  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand     = (int'(gnt_idx_q) + k) % NUM_MASTERS;
            cand_idx = cand[IDX_W-1:0];
            if (!found && bus.m_cyc[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_q;
        gnt_next       = gnt_q;
        gnt_idx_next   = gnt_idx_q;
        gnt_valid_next = gnt_valid_q;
        to_err_next    = 1'b0;
        cnt_next       = cnt_q;

        unique case (state_q)
            IDLE: begin
                cnt_next = '0;
                if (|bus.m_cyc) begin
                    state_next       = BUSY;
                    gnt_next         = '0;
                    gnt_next[winner] = 1'b1;
                    gnt_idx_next     = winner;
                    gnt_valid_next   = 1'b1;
                end
            end
            BUSY: begin
                // Release takes precedence over a watchdog expiry in the same cycle.
                if (!bus.m_cyc[gnt_idx_q]) begin
                    state_next     = IDLE;
                    gnt_next       = '0;
                    gnt_valid_next = 1'b0;
                    cnt_next       = '0;
                end else if (term) begin
                    cnt_next = '0;
                end else if (cnt_q == CNT_LAST) begin
                    to_err_next = 1'b1;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_q + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= IDX_RST;
            gnt_valid_q <= 1'b0;
            to_err_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_next;
            gnt_q       <= gnt_next;
            gnt_idx_q   <= gnt_idx_next;
            gnt_valid_q <= gnt_valid_next;
            to_err_q    <= to_err_next;
            cnt_q       <= cnt_next;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.to_err    = to_err_q;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with 4 masters and an 8-cycle watchdog.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_wb_rr_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    wb_rr_arbiter_if #(.NUM_MASTERS(4)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS(4),
        .TIMEOUT    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.m_cyc  = 4'b0000;
        bus.s_ack  = 1'b0;
        bus.s_err  = 1'b0;
        bus.s_rty  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.gnt_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.gnt_valid); end
        checks++; if (bus.gnt_idx !== 2'd3) begin fails++; $display("[TB] FAIL reset_idx: got %0d expected 3", bus.gnt_idx); end
        checks++; if (bus.to_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_to_err: got %b expected 0", bus.to_err); end

        bus.m_cyc = 4'b0001;
        step();
        checks++; if (bus.gnt !== 4'b0001) begin fails++; $display("[TB] FAIL pre_async_gnt: got %b expected 0001", bus.gnt); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL async_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.gnt_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_valid: got %b expected 0", bus.gnt_valid); end
        checks++; if (bus.gnt_idx !== 2'd3) begin fails++; $display("[TB] FAIL async_idx: got %0d expected 3", bus.gnt_idx); end
        checks++; if (bus.to_err !== 1'b0) begin fails++; $display("[TB] FAIL async_to_err: got %b expected 0", bus.to_err); end
        rst       = 1'b0;
        bus.m_cyc = 4'b0000;
        step();
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL post_async_idle: got %b expected 0000", bus.gnt); end
    endtask

    task automatic test_round_robin();
        int         owner;
        logic [3:0] exp_gnt;
        bus.m_cyc = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            owner   = k % 4;
            exp_gnt = 4'b0001 << owner;
            checks++; if (bus.gnt !== exp_gnt) begin fails++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, bus.gnt, exp_gnt); end
            checks++; if (bus.gnt_idx !== 2'(owner)) begin fails++; $display("[TB] FAIL rr_idx[%0d]: got %0d expected %0d", k, bus.gnt_idx, owner); end
            checks++; if (bus.gnt_valid !== 1'b1) begin fails++; $display("[TB] FAIL rr_valid[%0d]: got %b expected 1", k, bus.gnt_valid); end
            for (int j = 0; j < 3; j++) begin
                bus.s_ack = 1'b1;
                step();
                checks++; if (bus.gnt !== exp_gnt) begin fails++; $display("[TB] FAIL rr_hold[%0d.%0d]: got %b expected %b", k, j, bus.gnt, exp_gnt); end
            end
            bus.s_ack        = 1'b0;
            bus.m_cyc[owner] = 1'b0;
            step();
            checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL rr_dead_gnt[%0d]: got %b expected 0000", k, bus.gnt); end
            checks++; if (bus.gnt_valid !== 1'b0) begin fails++; $display("[TB] FAIL rr_dead_valid[%0d]: got %b expected 0", k, bus.gnt_valid); end
            checks++; if (bus.gnt_idx !== 2'(owner)) begin fails++; $display("[TB] FAIL rr_dead_idx[%0d]: got %0d expected %0d", k, bus.gnt_idx, owner); end
            bus.m_cyc = (k == 4) ? 4'b0000 : 4'b1111;
            step();
        end
    endtask

    task automatic test_no_preempt();
        bus.m_cyc = 4'b0100;
        step();
        bus.m_cyc = 4'b0101;
        bus.s_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++; if (bus.gnt !== 4'b0100) begin fails++; $display("[TB] FAIL np_gnt[%0d]: got %b expected 0100", c, bus.gnt); end
            checks++; if (bus.to_err !== 1'b0) begin fails++; $display("[TB] FAIL np_to_err[%0d]: got %b expected 0", c, bus.to_err); end
            step();
        end
        checks++; if (bus.gnt !== 4'b0100) begin fails++; $display("[TB] FAIL np_gnt_last: got %b expected 0100", bus.gnt); end
        bus.m_cyc = 4'b0001;
        bus.s_ack = 1'b0;
        step();
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL np_dead: got %b expected 0000", bus.gnt); end
        step();
        checks++; if (bus.gnt !== 4'b0001) begin fails++; $display("[TB] FAIL np_next_gnt: got %b expected 0001", bus.gnt); end
        checks++; if (bus.gnt_idx !== 2'd0) begin fails++; $display("[TB] FAIL np_next_idx: got %0d expected 0", bus.gnt_idx); end
        bus.m_cyc = 4'b0000;
        step();
    endtask

    task automatic test_watchdog();
        logic exp_to;
        bus.m_cyc = 4'b0010;
        step();
        for (int c = 0; c < 20; c++) begin
            exp_to = (c == 8) || (c == 16);
            checks++; if (bus.gnt !== 4'b0010) begin fails++; $display("[TB] FAIL wd_gnt[%0d]: got %b expected 0010", c, bus.gnt); end
            checks++; if (bus.to_err !== exp_to) begin fails++; $display("[TB] FAIL wd_to_err[g+%0d]: got %b expected %b", c, bus.to_err, exp_to); end
            step();
        end
        bus.m_cyc = 4'b0000;
        step();
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL wd_release: got %b expected 0000", bus.gnt); end
    endtask

    task automatic test_boundary();
        logic exp_to;
        bus.m_cyc = 4'b0010;
        step();
        for (int c = 0; c <= 16; c++) begin
            bus.s_rty = (c == 7);
            exp_to    = (c == 16);
            checks++; if (bus.to_err !== exp_to) begin fails++; $display("[TB] FAIL rty_to_err[g+%0d]: got %b expected %b", c, bus.to_err, exp_to); end
            step();
        end
        bus.s_rty = 1'b0;
        bus.m_cyc = 4'b0000;
        step();
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL rty_release: got %b expected 0000", bus.gnt); end

        bus.m_cyc = 4'b0010;
        step();
        for (int c = 0; c < 8; c++) begin
            checks++; if (bus.gnt !== 4'b0010) begin fails++; $display("[TB] FAIL drop_gnt[%0d]: got %b expected 0010", c, bus.gnt); end
            checks++; if (bus.to_err !== 1'b0) begin fails++; $display("[TB] FAIL drop_to_err[%0d]: got %b expected 0", c, bus.to_err); end
            if (c == 7) bus.m_cyc = 4'b0000;
            step();
        end
        checks++; if (bus.to_err !== 1'b0) begin fails++; $display("[TB] FAIL drop_boundary_to_err: got %b expected 0", bus.to_err); end
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("[TB] FAIL drop_boundary_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.gnt_valid !== 1'b0) begin fails++; $display("[TB] FAIL drop_boundary_valid: got %b expected 0", bus.gnt_valid); end
        step();
        checks++; if (bus.to_err !== 1'b0) begin fails++; $display("[TB] FAIL drop_after_to_err: got %b expected 0", bus.to_err); end
    endtask

    task automatic test_single_requester();
        logic [3:0] exp_gnt;
        int         ph;
        for (int c = 0; c < 24; c++) begin
            ph      = c % 8;
            exp_gnt = (ph >= 1 && ph <= 4) ? 4'b1000 : 4'b0000;
            checks++; if (bus.gnt !== exp_gnt) begin fails++; $display("[TB] FAIL single_gnt[%0d]: got %b expected %b", c, bus.gnt, exp_gnt); end
            checks++; if (bus.to_err !== 1'b0) begin fails++; $display("[TB] FAIL single_to_err[%0d]: got %b expected 0", c, bus.to_err); end
            if (c >= 1) begin
                checks++; if (bus.gnt_idx !== 2'd3) begin fails++; $display("[TB] FAIL single_idx[%0d]: got %0d expected 3", c, bus.gnt_idx); end
            end
            bus.m_cyc = (ph < 4) ? 4'b1000 : 4'b0000;
            bus.s_err = (ph >= 5);
            step();
        end
        bus.m_cyc = 4'b0000;
        bus.s_err = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_round_robin();
        test_no_preempt();
        test_watchdog();
        test_boundary();
        test_single_requester();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
